// File: rtl/ms_countdown_timer.sv
// ms_countdown_timer
// Minutes:seconds countdown timer built from three cascaded BCD digit counters
// (seconds units MOD10, seconds tens MOD6, minutes MOD10) with a tick prescaler.
//
// Parameters:
//   TICK_DIV    enabled clk cycles per one-second decrement (1..1024)
// Ports:
//   clk         system clock, rising edge
//   clear       asynchronous active-low reset
//   load        synchronous active-low load of the clamped preset digits
//   enab        count enable, active-high
//   sec_uni_in  preset seconds units (values above 9 clamp to 9)
//   sec_dez_in  preset seconds tens  (values above 5 clamp to 5)
//   min_in      preset minutes       (values above 9 clamp to 9)
//   sec_uni     current seconds units
//   sec_dez     current seconds tens
//   min         current minutes
//   zero        combinational, high when the display reads 0:00
//   done        one-cycle pulse when a tick brings the count to 0:00
module ms_countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic       enab,
  input  logic [3:0] sec_uni_in,
  input  logic [3:0] sec_dez_in,
  input  logic [3:0] min_in,
  output logic [3:0] sec_uni,
  output logic [3:0] sec_dez,
  output logic [3:0] min,
  output logic       zero,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);

  logic [3:0]    uni_q, uni_d;
  logic [3:0]    dez_q, dez_d;
  logic [3:0]    min_q, min_d;
  logic [PW-1:0] pres_q, pres_d;
  logic          done_q, done_d;

  assign sec_uni = uni_q;
  assign sec_dez = dez_q;
  assign min     = min_q;
  assign done    = done_q;
  assign zero    = (uni_q == 4'd0) && (dez_q == 4'd0) && (min_q == 4'd0);

  always_comb begin
    uni_d  = uni_q;
    dez_d  = dez_q;
    min_d  = min_q;
    pres_d = pres_q;
    done_d = 1'b0;
    if (!load) begin
      // Load wins over any tick in the same cycle.
      uni_d  = (sec_uni_in > 4'd9) ? 4'd9 : sec_uni_in;
      dez_d  = (sec_dez_in > 4'd5) ? 4'd5 : sec_dez_in;
      min_d  = (min_in > 4'd9) ? 4'd9 : min_in;
      pres_d = '0;
    end else if (zero) begin
      // Terminal: no ticks at 0:00, so no wrap to 9:59 and no repeat done.
      pres_d = '0;
    end else if (enab) begin
      if (pres_q == PresMax) begin
        pres_d = '0;
        // Tick: decrement with cascaded borrow. Minutes never borrow since
        // zero suppresses ticks.
        if (uni_q == 4'd0) begin
          uni_d = 4'd9;
          if (dez_q == 4'd0) begin
            dez_d = 4'd5;
            min_d = min_q - 4'd1;
          end else begin
            dez_d = dez_q - 4'd1;
          end
        end else begin
          uni_d = uni_q - 4'd1;
        end
        done_d = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd1);
      end else begin
        pres_d = pres_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      uni_q  <= 4'd0;
      dez_q  <= 4'd0;
      min_q  <= 4'd0;
      pres_q <= '0;
      done_q <= 1'b0;
    end else begin
      uni_q  <= uni_d;
      dez_q  <= dez_d;
      min_q  <= min_d;
      pres_q <= pres_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Testbench for ms_countdown_timer: two instances (TICK_DIV=1 and TICK_DIV=4)
// share stimulus; expected observations are queued per cycle and compared
// after each rising edge.
module tb_ms_countdown_timer;

  logic       clk = 1'b0;
  logic       clear, load, enab;
  logic [3:0] p_uni, p_dez, p_min;
  logic [3:0] u1, d1, m1, u4, d4, m4;
  logic       z1, dn1, z4, dn4;
  logic [13:0] obs1, obs4;

  always #5 clk = ~clk;

  ms_countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .clear(clear), .load(load), .enab(enab),
    .sec_uni_in(p_uni), .sec_dez_in(p_dez), .min_in(p_min),
    .sec_uni(u1), .sec_dez(d1), .min(m1), .zero(z1), .done(dn1)
  );

  ms_countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .clear(clear), .load(load), .enab(enab),
    .sec_uni_in(p_uni), .sec_dez_in(p_dez), .min_in(p_min),
    .sec_uni(u4), .sec_dez(d4), .min(m4), .zero(z4), .done(dn4)
  );

  assign obs1 = {m1, d1, u1, z1, dn1};
  assign obs4 = {m4, d4, u4, z4, dn4};

  typedef struct {
    string       name;
    bit          sel4;
    logic [13:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  // Expected observation from a remaining-seconds count.
  function automatic logic [13:0] mk(int s, bit dn);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10), (s == 0), dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input int s);
    p_min = 4'(s / 60);
    p_dez = 4'((s % 60) / 10);
    p_uni = 4'(s % 10);
  endtask

  task automatic test_reset();
    sb_t e;
    logic [13:0] got;
    clear = 1'b0; load = 1'b1; enab = 1'b0; set_preset(0);
    #3;
    sb.push_back('{name: "reset_d1", sel4: 1'b0, exp: mk(0, 1'b0)});
    sb.push_back('{name: "reset_d4", sel4: 1'b1, exp: mk(0, 1'b0)});
    repeat (2) begin
      e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    #3 clear = 1'b1;
    enab = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{name: "idle_zero_d1", sel4: 1'b0, exp: mk(0, 1'b0)});
      sb.push_back('{name: "idle_zero_d4", sel4: 1'b1, exp: mk(0, 1'b0)});
      step();
      repeat (2) begin
        e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_div1();
    sb_t e;
    logic [13:0] got;
    int s;
    load = 1'b0; enab = 1'b0; set_preset(60);
    sb.push_back('{name: "load_1_00_d1", sel4: 1'b0, exp: mk(60, 1'b0)});
    sb.push_back('{name: "load_1_00_d4", sel4: 1'b1, exp: mk(60, 1'b0)});
    step();
    repeat (2) begin
      e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    load = 1'b1; enab = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      s = (60 - i > 0) ? 60 - i : 0;
      sb.push_back('{name: $sformatf("div1_tick%0d", i), sel4: 1'b0, exp: mk(s, i == 60)});
      step();
      e = sb.pop_front(); got = obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_div4();
    sb_t e;
    logic [13:0] got;
    int s;
    int en_cnt;
    bit en_pat[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    load = 1'b0; enab = 1'b0; set_preset(3);
    sb.push_back('{name: "div4_load", sel4: 1'b1, exp: mk(3, 1'b0)});
    step();
    e = sb.pop_front(); got = obs4; n_vec++;
    if (got !== e.exp) begin
      n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
    end
    load = 1'b1; enab = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      s = (3 - k / 4 > 0) ? 3 - k / 4 : 0;
      sb.push_back('{name: $sformatf("div4_edge%0d", k), sel4: 1'b1, exp: mk(s, k == 12)});
      step();
      e = sb.pop_front(); got = obs4; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    // Reload, then pause enab for two edges mid-interval.
    load = 1'b0; enab = 1'b0; set_preset(3);
    step();
    load = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      enab = en_pat[k];
      if (en_pat[k]) en_cnt++;
      sb.push_back('{name: $sformatf("div4_pause_edge%0d", k + 1), sel4: 1'b1,
                     exp: mk(3 - en_cnt / 4, 1'b0)});
      step();
      e = sb.pop_front(); got = obs4; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_clamp();
    sb_t e;
    logic [13:0] got;
    load = 1'b0; enab = 1'b0;
    p_min = 4'd12; p_dez = 4'd7; p_uni = 4'd15;
    sb.push_back('{name: "clamp_d1", sel4: 1'b0, exp: mk(599, 1'b0)});
    sb.push_back('{name: "clamp_d4", sel4: 1'b1, exp: mk(599, 1'b0)});
    step();
    repeat (2) begin
      e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    load = 1'b1; enab = 1'b1;
    sb.push_back('{name: "clamp_tick_d1", sel4: 1'b0, exp: mk(598, 1'b0)});
    sb.push_back('{name: "clamp_notick_d4", sel4: 1'b1, exp: mk(599, 1'b0)});
    step();
    repeat (2) begin
      e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [13:0] got;
    // Each row: load, enab, preset seconds, expected dut1 seconds after edge.
    int rows[7][4] = '{'{0, 0, 5, 5}, '{0, 1, 30, 30}, '{1, 1, 0, 29}, '{0, 0, 1, 1},
                       '{0, 1, 0, 0}, '{1, 1, 0, 0}, '{1, 1, 0, 0}};
    for (int r = 0; r < 7; r++) begin
      load = rows[r][0][0]; enab = rows[r][1][0]; set_preset(rows[r][2]);
      sb.push_back('{name: $sformatf("b2b_row%0d", r), sel4: 1'b0, exp: mk(rows[r][3], 1'b0)});
      step();
      e = sb.pop_front(); got = obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    sb_t e;
    logic [13:0] got;
    load = 1'b0; enab = 1'b0; set_preset(210);
    step();
    load = 1'b1; enab = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{name: $sformatf("pre_reset%0d", i), sel4: 1'b0, exp: mk(210 - i, 1'b0)});
      step();
      e = sb.pop_front(); got = obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    #2 clear = 1'b0;
    #1;
    sb.push_back('{name: "async_reset_d1", sel4: 1'b0, exp: mk(0, 1'b0)});
    sb.push_back('{name: "async_reset_d4", sel4: 1'b1, exp: mk(0, 1'b0)});
    repeat (2) begin
      e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    #1 clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{name: "post_reset_d1", sel4: 1'b0, exp: mk(0, 1'b0)});
      sb.push_back('{name: "post_reset_d4", sel4: 1'b1, exp: mk(0, 1'b0)});
      step();
      repeat (2) begin
        e = sb.pop_front(); got = e.sel4 ? obs4 : obs1; n_vec++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div4();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ms_countdown_timer.md
# ms_countdown_timer

Minutes:seconds countdown timer for the microwave controller, built around the same digit-counter behaviour as the tens-of-seconds MOD6 stage. It takes the load and count-enable controls that drive the individual digit counters and cascades three BCD digits: seconds units (MOD10), seconds tens (MOD6) and minutes (MOD10). An internal tick prescaler sets the count rate. It reports `zero` and a one-cycle `done` pulse to the control FSM, and drives the digit outputs to the display decoder.

## Interface
- `TICK_DIV`, default 1: number of enabled `clk` cycles per one-second decrement; legal range 1..1024.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `clear`  input  1  asynchronous, active-low reset.
- `load`  input  1  synchronous, active-low load of the preset digits.
- `enab`  input  1  count enable, active-high; prescaler advances only while high.
- `sec_uni_in`  input  4  preset, seconds units (BCD).
- `sec_dez_in`  input  4  preset, seconds tens (BCD).
- `min_in`  input  4  preset, minutes (BCD).
- `sec_uni`  output  4  current seconds units, 0..9.
- `sec_dez`  output  4  current seconds tens, 0..5.
- `min`  output  4  current minutes, 0..9.
- `zero`  output  1  combinational; high when all three digits are 0.
- `done`  output  1  registered one-cycle pulse on a count-driven arrival at 0:00.

## Operation
- **Reset** (`clear`=0, asynchronous):
  - `sec_uni`, `sec_dez` and `min` = 0; prescaler = 0; `done` = 0.
  - Consequently `zero` = 1.
  - Reset overrides everything, including an in-progress count.
- **Load** (`load`=0 at a rising edge):
  - Digits take the presets, with clamping: `sec_uni_in`>9 → 9, `sec_dez_in`>5 → 5, `min_in`>9 → 9.
  - Prescaler is cleared to 0 and `done` = 0.
  - Load has priority over `enab`.
- **Prescaler**:
  - On an edge with `load`=1, `enab`=1 and `zero`=0, the prescaler increments.
  - When it equals `TICK_DIV`-1 it wraps to 0 and generates a tick in the same edge.
  - With `enab`=0 it holds.
  - With `zero`=1 it is forced to 0.
- **Decrement on tick** (cascaded borrow):
  - `sec_uni` -1. If it was 0, it becomes 9 and borrows from `sec_dez`.
  - On a borrow, `sec_dez` -1. If it was 0, it becomes 5 and borrows from `min`.
  - On a borrow, `min` -1.
  - A borrow out of minutes cannot occur, because ticks are suppressed at 0:00.
- **Terminal**:
  - At 0:00 the count holds and never wraps to 9:59.
  - `zero` stays 1 until a load of a non-zero value.
- **`done`**:
  - Set at the edge where a tick moves the count from 0:01 to 0:00.
  - Cleared at the next edge.
  - Loading 0:00 never asserts `done`.
- **Held inputs**: `enab` held high at 0:00 produces no further ticks and no further `done`.

## Timing
- Load latency: digits are valid 1 cycle after the sampling edge.
- Count rate with `TICK_DIV`=N: after a load, the first decrement occurs at the Nth enabled edge, then every N enabled edges.
  - Edges with `enab`=0 are not counted and stretch the interval.
- `zero` follows the digit registers combinationally: same cycle as the digit change, no extra latency.
- `done` is high for exactly one cycle, the cycle in which the digits first read 0:00.
- **Simultaneous load and tick**: load wins; no decrement that cycle.
- **`enab` dropped mid-interval**: the prescaler value is preserved, and counting resumes where it stopped.
- **Reset mid-count**: immediate return to reset values, asynchronously, independent of `clk`.

## Test plan
- Reset, then release:
  - Required: digits 0:00, `zero`=1, `done`=0.
  - 5 cycles with `enab`=1: digits remain 0:00, `done` never asserts.
- `TICK_DIV`=1: load 1:00 (`min_in`=1, `sec_dez_in`=0, `sec_uni_in`=0), then `enab`=1.
  - Required sequence: 1:00 → 0:59 → 0:58.
  - After 60 ticks: 0:00 with `done`=1 for exactly 1 cycle, then hold.
- `TICK_DIV`=4: load 0:03, `enab`=1.
  - Required: 0:02 after the 4th edge, 0:00 after the 12th edge, `done` pulse then.
  - Also toggle `enab` low for 2 cycles mid-interval: the decrement is delayed by exactly 2 cycles.
- Load clamping: load `min_in`=12, `sec_dez_in`=7, `sec_uni_in`=15.
  - Required: 9:59.
  - One tick later: 9:58.
- Simultaneous load and count:
  - At 0:05 with `enab`=1 and `load`=0 presenting 0:30: next cycle reads 0:30, not 0:04.
  - Loading 0:00 gives `zero`=1, `done`=0.
- Asynchronous reset at 3:27 mid-count, asserted between clock edges:
  - Required: digits become 0:00 immediately.
  - No `done` pulse after `clear` returns high.
